// File: rtl/vga_pos_fetch_if.sv
// Memory read port, frame input and bit-generator load bus for vga_pos_fetch.
// master = the fetch block, slave = arbiter/memory/bit generator side.
interface vga_pos_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              frame;
    logic              vga_req;
    logic              vga_gnt;
    logic              rd_en;
    logic [ADDR_W-1:0] addr_vga;
    logic [15:0]       mem_rdata;
    logic [15:0]       data_from_mem_vga;
    logic [2:0]        vga_counter;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        input  frame, vga_gnt, mem_rdata,
        output vga_req, rd_en, addr_vga, data_from_mem_vga,
        output vga_counter, busy, done, overrun
    );

    modport slave (
        output frame, vga_gnt, mem_rdata,
        input  vga_req, rd_en, addr_vga, data_from_mem_vga,
        input  vga_counter, busy, done, overrun
    );
endinterface

// File: rtl/vga_pos_fetch.sv
// Per-frame fetch of the sprite position words into the VGA bit generator.
// Define VGA_FETCH_TIMEOUT_EN for the grant timeout and its fetch_err port.
module vga_pos_fetch #(
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 32'h3F00,
    parameter int          NUM_WORDS = 6,
    parameter int          MEM_LAT   = 1
`ifdef VGA_FETCH_TIMEOUT_EN
    ,
    parameter int          GNT_TIMEOUT = 255
`endif
) (
    input  logic            clk,
    input  logic            reset,
    vga_pos_fetch_if.master bus
`ifdef VGA_FETCH_TIMEOUT_EN
    ,
    output logic            fetch_err
`endif
);

    localparam int                LW       = $clog2(MEM_LAT + 1);
    localparam logic [2:0]        LAST_IDX = 3'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, LAST, DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [15:0]       data_q, data_d;
    logic [2:0]        code_q, code_d;
    logic              req, rd, fin, busy;
    logic [ADDR_W-1:0] addr;

`ifdef VGA_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(GNT_TIMEOUT + 1);
    logic [TW-1:0] wcnt_q, wcnt_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        data_d  = data_q;
        code_d  = '0;
        req     = 1'b0;
        rd      = 1'b0;
        addr    = '0;
        fin     = 1'b0;
`ifdef VGA_FETCH_TIMEOUT_EN
        wcnt_d    = '0;
        fetch_err = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.frame) state_d = ISSUE;
            end
            ISSUE: begin
                req = 1'b1;
                if (bus.vga_gnt) begin
                    rd      = 1'b1;
                    addr    = BASE + ADDR_W'(idx_q);
                    lat_d   = LW'(MEM_LAT);
                    state_d = WAIT;
                end
`ifdef VGA_FETCH_TIMEOUT_EN
                else if (wcnt_q == TW'(GNT_TIMEOUT - 1)) begin
                    fetch_err = 1'b1;
                    idx_d     = '0;
                    state_d   = IDLE;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
`endif
            end
            WAIT: begin
                // Grant is not needed here: the read is already in flight.
                req   = 1'b1;
                lat_d = lat_q - LW'(1);
                if (lat_q == LW'(1)) begin
                    data_d = bus.mem_rdata;
                    code_d = idx_q + 3'd1;
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ISSUE;
                    end else begin
                        state_d = LAST;
                    end
                end
            end
            LAST: begin
                state_d = DONE;
            end
            DONE: begin
                fin     = 1'b1;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            code_q  <= '0;
`ifdef VGA_FETCH_TIMEOUT_EN
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            code_q  <= code_d;
`ifdef VGA_FETCH_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    assign busy                  = (state_q != IDLE);
    assign bus.busy              = busy;
    assign bus.overrun           = bus.frame & busy;
    assign bus.vga_req           = req;
    assign bus.rd_en             = rd;
    assign bus.addr_vga          = addr;
    assign bus.done              = fin;
    assign bus.data_from_mem_vga = data_q;
    assign bus.vga_counter       = code_q;

endmodule

// File: tb/tb_vga_pos_fetch.sv
// Bench for vga_pos_fetch: MEM_LAT=1 and MEM_LAT=3 instances on shared stimulus,
// checked each cycle against a timeline model plus literal timing pins.
module tb_vga_pos_fetch;

    localparam int BASE = 32'h3F00;
    localparam int NW   = 6;
    localparam int TO   = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic frame = 1'b0;
    logic gnt   = 1'b0;

    int cyc      = 0;
    int fbase    = 0;
    int checks   = 0;
    int errors   = 0;
    int clr_gen  = 0;
    int clr_seen = 0;
    int lit_scn  = 0;
    int lit_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input int i);
        case (i)
            0, 1:    return 16'h0064;
            2, 3:    return 16'h00C8;
            4, 5:    return 16'h012C;
            default: return 16'hBAD0;
        endcase
    endfunction

    function automatic logic [15:0] mrd(input logic [15:0] a);
        return mem_word(int'(a) - BASE);
    endfunction

    vga_pos_fetch_if #(.ADDR_W(16)) i1 ();
    vga_pos_fetch_if #(.ADDR_W(16)) i3 ();

    assign i1.frame   = frame;
    assign i1.vga_gnt = gnt;
    assign i3.frame   = frame;
    assign i3.vga_gnt = gnt;

`ifdef VGA_FETCH_TIMEOUT_EN
    logic fe1, fe3;
`endif

    vga_pos_fetch #(
        .ADDR_W(16), .BASE_ADDR(BASE), .NUM_WORDS(NW), .MEM_LAT(1)
`ifdef VGA_FETCH_TIMEOUT_EN
        , .GNT_TIMEOUT(TO)
`endif
    ) u1 (
        .clk(clk), .reset(reset), .bus(i1)
`ifdef VGA_FETCH_TIMEOUT_EN
        , .fetch_err(fe1)
`endif
    );

    vga_pos_fetch #(
        .ADDR_W(16), .BASE_ADDR(BASE), .NUM_WORDS(NW), .MEM_LAT(3)
`ifdef VGA_FETCH_TIMEOUT_EN
        , .GNT_TIMEOUT(TO)
`endif
    ) u3 (
        .clk(clk), .reset(reset), .bus(i3)
`ifdef VGA_FETCH_TIMEOUT_EN
        , .fetch_err(fe3)
`endif
    );

    // Memories: data valid exactly MEM_LAT cycles after rd_en, junk otherwise.
    logic        v1 = 1'b0;
    logic [15:0] a1 = '0;
    logic [2:0]  v3 = '0;
    logic [15:0] a3 [3];

    always @(posedge clk) begin
        v1    <= i1.rd_en;
        a1    <= i1.addr_vga;
        v3    <= {v3[1:0], i3.rd_en};
        a3[0] <= i3.addr_vga;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end

    assign i1.mem_rdata = v1 ? mrd(a1) : 16'hDEAD;
    assign i3.mem_rdata = v3[2] ? mrd(a3[2]) : 16'hDEAD;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s lat%0d rel_cyc %0d: got %0h want %0h",
                     nm, (k == 0) ? 1 : 3, cyc - fbase, act, exp);
        end
    endtask

    // Model state: burst timeline per instance
    bit          m_act  [2];
    int          m_next [2];
    int          m_iss  [2];
    int          m_pt   [2];
    int          m_pc   [2];
    int          m_done [2];
    int          m_wc   [2];
    logic [15:0] m_pd   [2];
    logic [15:0] m_data [2];

    // Observation logs, relative to fbase
    int ccyc [2][8];
    int cdat [2][8];
    int ccnt [2];
    int rdn  [2];
    int dcyc [2];
    int ocyc [2];
    int fecyc[2];
    int fa   [2];
    int rq11 [2];

    logic        a_req, a_rd, a_busy, a_done, a_ovr, a_fe;
    logic [15:0] a_addr, a_data;
    logic [2:0]  a_cnt;
    logic        e_req, e_rd, e_busy, e_done, e_ovr, e_fe, issuing, was;
    logic [15:0] e_addr, e_data;
    logic [2:0]  e_cnt;
    int          lat, c, rel;

    task automatic literal(input int s);
        case (s)
            1: begin
                chk("s1_rdn",   0, rdn[0], 6);
                chk("s1_code1", 0, ccyc[0][1], 3);
                chk("s1_code6", 0, ccyc[0][6], 13);
                chk("s1_done",  0, dcyc[0], 14);
                chk("s1_data3", 0, cdat[0][3], 'h00C8);
                chk("s1_data6", 0, cdat[0][6], 'h012C);
                chk("s1_rdn",   1, rdn[1], 6);
                chk("s1_code1", 1, ccyc[1][1], 5);
                chk("s1_code6", 1, ccyc[1][6], 25);
                chk("s1_done",  1, dcyc[1], 26);
            end
            2: begin
                chk("s2_code3", 0, ccyc[0][3], 12);
                chk("s2_done",  0, dcyc[0], 19);
                chk("s2_ncode", 0, ccnt[0], 6);
                chk("s2_rdn",   0, rdn[0], 6);
                chk("s2_code2", 1, ccyc[1][2], 14);
                chk("s2_done",  1, dcyc[1], 31);
                chk("s2_ncode", 1, ccnt[1], 6);
            end
            3: begin
                chk("s3_ovr",   0, ocyc[0], 6);
                chk("s3_ncode", 0, ccnt[0], 6);
                chk("s3_ovr",   1, ocyc[1], 6);
                chk("s3_ncode", 1, ccnt[1], 6);
            end
            4: begin
                chk("s4_addr0", 0, fa[0], BASE);
                chk("s4_code1", 0, ccyc[0][1], 3);
                chk("s4_addr0", 1, fa[1], BASE);
                chk("s4_ncode", 1, ccnt[1], 6);
            end
`ifdef VGA_FETCH_TIMEOUT_EN
            5: begin
                for (int k = 0; k < 2; k++) begin
                    chk("s5_ferr",  k, fecyc[k], 10);
                    chk("s5_req11", k, rq11[k], 0);
                    chk("s5_ncode", k, ccnt[k], 0);
                    chk("s5_done",  k, dcyc[k], -1);
                end
            end
`endif
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (clr_gen != clr_seen) begin
            clr_seen = clr_gen;
            for (int k = 0; k < 2; k++) begin
                ccnt[k] = 0; rdn[k] = 0; dcyc[k] = -1; ocyc[k] = -1;
                fecyc[k] = -1; fa[k] = -1; rq11[k] = -1;
                for (int j = 0; j < 8; j++) begin
                    ccyc[k][j] = -1;
                    cdat[k][j] = -1;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                a_req = i1.vga_req; a_rd = i1.rd_en; a_addr = i1.addr_vga;
                a_data = i1.data_from_mem_vga; a_cnt = i1.vga_counter;
                a_busy = i1.busy; a_done = i1.done; a_ovr = i1.overrun;
`ifdef VGA_FETCH_TIMEOUT_EN
                a_fe = fe1;
`else
                a_fe = 1'b0;
`endif
            end else begin
                a_req = i3.vga_req; a_rd = i3.rd_en; a_addr = i3.addr_vga;
                a_data = i3.data_from_mem_vga; a_cnt = i3.vga_counter;
                a_busy = i3.busy; a_done = i3.done; a_ovr = i3.overrun;
`ifdef VGA_FETCH_TIMEOUT_EN
                a_fe = fe3;
`else
                a_fe = 1'b0;
`endif
            end
            lat = (k == 0) ? 1 : 3;
            c   = cyc;
            issuing = 1'b0;
            e_fe    = 1'b0;
            if (reset) begin
                m_act[k] = 1'b0; m_next[k] = 0; m_pt[k] = -1;
                m_done[k] = -1; m_wc[k] = 0; m_data[k] = '0;
                e_req = 0; e_rd = 0; e_addr = '0; e_cnt = '0;
                e_busy = 0; e_done = 0; e_ovr = 0;
            end else begin
                issuing = m_act[k] && m_next[k] < NW && c >= m_iss[k];
                e_req   = m_act[k] && (m_next[k] < NW || c < m_pt[k]);
                e_rd    = issuing && gnt;
                e_addr  = e_rd ? 16'(BASE + m_next[k]) : 16'h0;
                e_cnt   = '0;
                if (m_pt[k] == c) begin
                    e_cnt     = 3'(m_pc[k]);
                    m_data[k] = m_pd[k];
                end
                e_busy = m_act[k];
                e_done = m_act[k] && c == m_done[k];
                e_ovr  = frame && m_act[k];
`ifdef VGA_FETCH_TIMEOUT_EN
                e_fe   = issuing && !gnt && (m_wc[k] + 1 == TO);
`endif
            end
            e_data = m_data[k];

            chk("vga_req", k, a_req, e_req);
            chk("rd_en", k, a_rd, e_rd);
            chk("addr_vga", k, a_addr, e_addr);
            chk("data", k, a_data, e_data);
            chk("vga_counter", k, a_cnt, e_cnt);
            chk("busy", k, a_busy, e_busy);
            chk("done", k, a_done, e_done);
            chk("overrun", k, a_ovr, e_ovr);
`ifdef VGA_FETCH_TIMEOUT_EN
            chk("fetch_err", k, a_fe, e_fe);
`endif

            if (!reset) begin
                was = m_act[k];
                if (e_rd) begin
                    m_pt[k]  = c + lat + 1;
                    m_pc[k]  = m_next[k] + 1;
                    m_pd[k]  = mem_word(m_next[k]);
                    m_iss[k] = c + lat + 1;
                    m_next[k]++;
                    m_wc[k]  = 0;
                    if (m_next[k] == NW) m_done[k] = c + lat + 2;
                end else if (issuing) begin
                    m_wc[k]++;
                end
                if (e_fe || e_done) m_act[k] = 1'b0;
                if (!was && frame) begin
                    m_act[k] = 1'b1; m_next[k] = 0; m_iss[k] = c + 1;
                    m_pt[k] = -1; m_done[k] = -1; m_wc[k] = 0;
                end
            end

            rel = cyc - fbase;
            if (a_cnt != 3'd0) begin
                ccnt[k]++;
                if (ccyc[k][a_cnt] < 0) begin
                    ccyc[k][a_cnt] = rel;
                    cdat[k][a_cnt] = int'(a_data);
                end
            end
            if (a_rd) begin
                rdn[k]++;
                if (fa[k] < 0) fa[k] = int'(a_addr);
            end
            if (a_done && dcyc[k] < 0) dcyc[k] = rel;
            if (a_ovr && ocyc[k] < 0) ocyc[k] = rel;
            if (a_fe && fecyc[k] < 0) fecyc[k] = rel;
            if (rel == 11) rq11[k] = int'(a_req);
        end
        if (lit_scn != lit_seen) begin
            lit_seen = lit_scn;
            literal(lit_scn);
        end
    end

    task automatic tick(input logic f, input logic g);
        @(posedge clk);
        #1;
        frame = f;
        gnt   = g;
    endtask

    initial begin
        repeat (3) tick(1'b0, 1'b0);
        reset = 1'b0;
        tick(1'b0, 1'b0);

        // continuous grant
        clr_gen++;
        tick(1'b1, 1'b1);
        fbase = cyc;
        repeat (35) tick(1'b0, 1'b1);
        lit_scn = 1;
        tick(1'b0, 1'b1);

        // grant lost for relative cycles 5..9
        clr_gen++;
        tick(1'b1, 1'b1);
        fbase = cyc;
        for (int r = 1; r <= 44; r++) tick(1'b0, (r < 5 || r > 9));
        lit_scn = 2;
        tick(1'b0, 1'b1);

        // second frame while busy
        clr_gen++;
        tick(1'b1, 1'b1);
        fbase = cyc;
        for (int r = 1; r <= 35; r++) tick(r == 6, 1'b1);
        lit_scn = 3;
        tick(1'b0, 1'b1);

        // reset mid-burst, then a fresh burst
        tick(1'b1, 1'b1);
        fbase = cyc;
        for (int r = 1; r <= 6; r++) tick(1'b0, 1'b1);
        reset = 1'b1;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        reset = 1'b0;
        tick(1'b0, 1'b1);
        clr_gen++;
        tick(1'b1, 1'b1);
        fbase = cyc;
        repeat (35) tick(1'b0, 1'b1);
        lit_scn = 4;
        tick(1'b0, 1'b1);

`ifdef VGA_FETCH_TIMEOUT_EN
        // grant never given
        clr_gen++;
        tick(1'b1, 1'b0);
        fbase = cyc;
        repeat (20) tick(1'b0, 1'b0);
        lit_scn = 5;
        tick(1'b0, 1'b0);
`endif

        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pos_fetch.md
Name: vga_pos_fetch

Overview:
- Upstream feeder for the VGA sprite/bit generator stage.
- Once per frame, it reads the sprite position table (monkey x/y, platform 1 x/y, platform 2 x/y) from the shared data memory through an arbitrated read port.
- It presents each word to the bit generator with a one-hot-in-time load code: vga_counter 1..6 for one cycle, 0 otherwise.
- It sits between vga_control's frame pulse, the memory arbiter and the bit generator's data_from_mem_vga/vga_counter inputs.

Parameters:
- ADDR_W, 16, width of memory address.
- BASE_ADDR, 16'h3F00, address of word 0 (mx); words occupy BASE_ADDR..BASE_ADDR+5.
- NUM_WORDS, 6, words per frame; legal range 1..7.
- MEM_LAT, 1, read latency in cycles from rd_en to valid mem_rdata; legal range ≥1.
- GNT_TIMEOUT, 255, cycles to wait for grant before abandoning a frame (optional feature only).

Ports:
- clk  in  1  pixel-domain clock (25 MHz).
- reset  in  1  asynchronous, active-high reset.
- frame  in  1  single-cycle start-of-frame pulse from vga_control.
- vga_req  out  1  request for the memory read port.
- vga_gnt  in  1  grant from the arbiter; valid only while vga_req is high.
- rd_en  out  1  read strobe; high only in cycles where vga_gnt=1 and a read issues.
- addr_vga  out  ADDR_W  read address; equals BASE_ADDR+idx while rd_en=1, else 0.
- mem_rdata  in  16  read data; valid MEM_LAT cycles after rd_en.
- data_from_mem_vga  out  16  registered word to the bit generator.
- vga_counter  out  3  load code: idx+1 for exactly one cycle per word, 0 otherwise.
- busy  out  1  high from REQ entry until DONE exit.
- done  out  1  one-cycle pulse after the last word is presented.
- overrun  out  1  one-cycle pulse when frame arrives while busy.

Behaviour:
- Reset (async): state IDLE, idx=0.
  - All outputs are 0: vga_req, rd_en, addr_vga, data_from_mem_vga, vga_counter, busy, done, overrun.
- States:
  - IDLE: wait for frame. On frame=1 at edge t, enter ISSUE at t+1; vga_req=1 and busy=1 from t+1.
  - ISSUE: vga_req=1.
    - If vga_gnt=1 this cycle: rd_en=1, addr_vga=BASE_ADDR+idx, go to WAIT with latency counter=MEM_LAT.
    - If vga_gnt=0: hold, no read issued.
  - WAIT: vga_req stays 1; vga_gnt is ignored because the read is already issued. Decrement the latency counter each cycle. In the cycle where mem_rdata is valid (MEM_LAT cycles after issue), register data_from_mem_vga<=mem_rdata and vga_counter<=idx+1 at the closing edge.
  - The cycle after capture: vga_counter=idx+1 (exactly one cycle, then 0).
    - If idx+1<NUM_WORDS: idx increments and ISSUE is re-entered in that same cycle.
    - Else: go to DONE.
  - DONE: one cycle. done=1, vga_req=0, busy drops at the next edge, idx<=0, return to IDLE.
- Per-word period is MEM_LAT+1 cycles with continuous grant.
- With MEM_LAT=1 and frame at edge 0:
  - rd_en in cycles 1,3,5,7,9,11.
  - vga_counter=1..6 in cycles 3,5,7,9,11,13.
  - done in cycle 14.
- data_from_mem_vga holds its last value between presentations. Unused addresses never appear on addr_vga.
- Grant loss mid-burst: resume at the same idx when grant returns. Never restart from word 0 and never re-present a word.
- frame while busy: ignored, overrun=1 for that cycle, current burst continues unaffected.
- frame in the DONE cycle counts as busy: overrun, no new burst.
- Reset mid-burst: immediate abort. Outputs return to reset values. Words already presented stay loaded in the bit generator.

Optional Feature:
- Macro VGA_FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter counts consecutive ISSUE cycles with vga_gnt=0.
  - On reaching GNT_TIMEOUT, the burst is abandoned: vga_req=0, no further vga_counter codes, done not pulsed.
  - Output port fetch_err (1 bit) pulses high one cycle, then the block returns to IDLE.
  - The counter clears on any grant.
- Undefined: the block waits indefinitely for grant; fetch_err is absent from the port list.

Test Plan:
- Continuous grant, MEM_LAT=1, memory BASE..BASE+5 = 0x0064,0x0064,0x00C8,0x00C8,0x012C,0x012C; frame at cycle 0 -> vga_counter 1..6 in cycles 3,5,..,13 with matching data_from_mem_vga; done in cycle 14; rd_en exactly 6 times.
- Grant low for cycles 5-9 during word 2 issue -> no rd_en while low; word 2 issued on the first cycle grant returns; sequence 1..6 still complete, no duplicates, no skips.
- frame pulses at cycles 0 and 6 -> overrun=1 in cycle 6; single burst of 6 codes only.
- Reset asserted in cycle 6 of a burst -> all outputs 0 asynchronously; next frame starts a fresh burst at idx 0 (first address BASE_ADDR).
- MEM_LAT=3 -> rd_en spacing 4 cycles; each vga_counter code appears 4 cycles after its rd_en, one-cycle wide.
- VGA_FETCH_TIMEOUT_EN, GNT_TIMEOUT=10, grant never asserted -> fetch_err pulse in the 10th ISSUE cycle, vga_req low next cycle, vga_counter stays 0, no done.
